// File: rtl/iu_pkg.sv
// Shared opcodes, instruction field positions and FSM state encoding for the
// instruction unit.
package iu_pkg;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hD;
  localparam logic [3:0] OP_LOAD  = 4'hE;
  localparam logic [3:0] OP_STORE = 4'hF;

  localparam int OPC_MSB = 15, OPC_LSB = 12;
  localparam int DST_MSB = 11, DST_LSB = 9;
  localparam int OPA_MSB = 8,  OPA_LSB = 6;
  localparam int OPB_MSB = 5,  OPB_LSB = 3;
  localparam int MEM_MSB = 3,  MEM_LSB = 0;
  localparam int TGT_MSB = 7,  TGT_LSB = 0;

  typedef enum logic [2:0] {
    S_FETCH, S_LATCH, S_ISSUE, S_LOAD_WAIT, S_HALTED
  } iu_state_t;
endpackage

// File: rtl/iu_decode.sv
// Combinational instruction-register decode into eu fields and control classes.
// IU_JUMP_EN adds the jump class and target; without it 1100 decodes as NOP.
module iu_decode
  import iu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [3:0]  o_opcode,
  output logic [2:0]  o_dest,
  output logic [2:0]  o_opa,
  output logic [2:0]  o_opb,
  output logic [3:0]  o_mem,
  output logic        o_is_load,
`ifdef IU_JUMP_EN
  output logic        o_is_jmp,
  output logic [7:0]  o_tgt,
`endif
  output logic        o_is_halt
);
  logic [3:0] w_raw;

  assign w_raw     = i_ir[OPC_MSB:OPC_LSB];
  assign o_dest    = i_ir[DST_MSB:DST_LSB];
  assign o_opa     = i_ir[OPA_MSB:OPA_LSB];
  assign o_opb     = i_ir[OPB_MSB:OPB_LSB];
  assign o_mem     = i_ir[MEM_MSB:MEM_LSB];
  assign o_is_load = (w_raw == OP_LOAD);
  assign o_is_halt = (w_raw == OP_HALT);

`ifdef IU_JUMP_EN
  assign o_is_jmp  = (w_raw == OP_JMP);
  assign o_tgt     = i_ir[TGT_MSB:TGT_LSB];
  assign o_opcode  = w_raw;
`else
  // Jump disabled: eu sees a plain NOP for 1100.
  assign o_opcode  = (w_raw == OP_JMP) ? OP_NOP : w_raw;
`endif
endmodule

// File: rtl/iu.sv
// Instruction unit: FETCH/LATCH/ISSUE loop feeding the eu command interface,
// with a LOAD write-back hold cycle and HALT. Optional jumps via IU_JUMP_EN.
module iu
  import iu_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_rd_en,
  input  logic [15:0]         imem_data,
  output logic [3:0]          opcode,
  output logic [2:0]          opAAdr,
  output logic [2:0]          opBAder,
  output logic [2:0]          dest_reg,
  output logic [3:0]          storeDataAdr,
  output logic                issue_valid,
  output logic                halted,
  output logic [PC_WIDTH-1:0] pc
);
  iu_state_t           r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [15:0]         r_ir;
  logic                w_ir_ld;
  logic [3:0]          w_opcode;
  logic                w_is_load, w_is_halt;
`ifdef IU_JUMP_EN
  logic                w_is_jmp;
  logic [7:0]          w_tgt;
`endif

  iu_decode u_dec (
    .i_ir      (r_ir),
    .o_opcode  (w_opcode),
    .o_dest    (dest_reg),
    .o_opa     (opAAdr),
    .o_opb     (opBAder),
    .o_mem     (storeDataAdr),
    .o_is_load (w_is_load),
`ifdef IU_JUMP_EN
    .o_is_jmp  (w_is_jmp),
    .o_tgt     (w_tgt),
`endif
    .o_is_halt (w_is_halt)
  );

  assign imem_addr = r_pc;
  assign pc        = r_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_ir_ld) r_ir <= imem_data;
    end
  end

  // Field outputs follow IR, so they hold their last values between issues.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_ld     = 1'b0;
    imem_rd_en  = 1'b0;
    issue_valid = 1'b0;
    opcode      = OP_NOP;
    halted      = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_rd_en  = ~reset;
        w_state_nxt = S_LATCH;
      end
      S_LATCH: begin
        w_ir_ld     = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        opcode      = w_opcode;
        w_pc_nxt    = r_pc + PC_WIDTH'(1);
        w_state_nxt = S_FETCH;
        if (w_is_load) begin
          w_state_nxt = S_LOAD_WAIT;
        end else if (w_is_halt) begin
          w_state_nxt = S_HALTED;
          w_pc_nxt    = r_pc;
        end
`ifdef IU_JUMP_EN
        else if (w_is_jmp) begin
          w_pc_nxt = PC_WIDTH'(w_tgt);
        end
`endif
      end
      S_LOAD_WAIT: begin
        opcode      = OP_LOAD;
        w_state_nxt = S_FETCH;
      end
      S_HALTED: halted = 1'b1;
      default:  w_state_nxt = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_iu.sv
// Self-checking bench for iu: directed program, halt/reset, random programs
// and pc wrap, checked against an instruction-level reference model.
module tb_iu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_data;
  logic [3:0]  opcode;
  logic [2:0]  opAAdr, opBAder, dest_reg;
  logic [3:0]  storeDataAdr;
  logic        issue_valid, halted;
  logic [7:0]  pc;

  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  logic [15:0] m_last;
  int          checks = 0;
  int          errors = 0;

  iu dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_data(imem_data), .opcode(opcode), .opAAdr(opAAdr), .opBAder(opBAder),
    .dest_reg(dest_reg), .storeDataAdr(storeDataAdr), .issue_valid(issue_valid),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the strobe.
  always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

  // Instruction-level semantics: issued opcode, next pc, load / halt class.
  function automatic void model(input logic [15:0] ins, input logic [7:0] cur,
                                output logic [3:0] eop, output logic [7:0] npc,
                                output bit ld, output bit hl);
    eop = ins[15:12];
    npc = cur + 8'd1;
    ld  = (eop == 4'hE);
    hl  = (eop == 4'hD);
    if (hl) npc = cur;
    if (eop == 4'hC) begin
`ifdef IU_JUMP_EN
      npc = ins[7:0];
`else
      eop = 4'h0;
`endif
    end
  endfunction

  // Walk one instruction cycle by cycle, starting in its FETCH cycle.
  task automatic run_instr(input string tag);
    logic [15:0] ins;
    logic [3:0]  eop;
    logic [7:0]  npc;
    bit          ld, hl;
    ins = mem[m_pc];
    model(ins, m_pc, eop, npc, ld, hl);
    checks++;
    if (imem_rd_en !== 1'b1 || imem_addr !== m_pc || pc !== m_pc || opcode !== 4'h0 ||
        issue_valid !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL %s fetch: rd_en=%b addr=%h pc=%h op=%h iv=%b hlt=%b, want rd_en=1 addr=pc=%h op=0",
               tag, imem_rd_en, imem_addr, pc, opcode, issue_valid, halted, m_pc);
    end
    @(negedge clk);
    checks++;
    if (imem_rd_en !== 1'b0 || opcode !== 4'h0 || issue_valid !== 1'b0 ||
        dest_reg !== m_last[11:9] || opAAdr !== m_last[8:6] || storeDataAdr !== m_last[3:0]) begin
      errors++;
      $display("FAIL %s latch: rd_en=%b op=%h iv=%b dst=%0d a=%0d mem=%h, want 0/0/0 held %0d/%0d/%h",
               tag, imem_rd_en, opcode, issue_valid, dest_reg, opAAdr, storeDataAdr,
               m_last[11:9], m_last[8:6], m_last[3:0]);
    end
    @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1 || opcode !== eop || dest_reg !== ins[11:9] || opAAdr !== ins[8:6] ||
        opBAder !== ins[5:3] || storeDataAdr !== ins[3:0] || imem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL %s issue ins=%h: iv=%b op=%h dst=%0d a=%0d b=%0d mem=%h, want iv=1 op=%h dst=%0d a=%0d b=%0d mem=%h",
               tag, ins, issue_valid, opcode, dest_reg, opAAdr, opBAder, storeDataAdr,
               eop, ins[11:9], ins[8:6], ins[5:3], ins[3:0]);
    end
    @(negedge clk);
    if (ld) begin
      checks++;
      if (issue_valid !== 1'b0 || opcode !== 4'hE || dest_reg !== ins[11:9] ||
          storeDataAdr !== ins[3:0] || imem_rd_en !== 1'b0) begin
        errors++;
        $display("FAIL %s load_wait: iv=%b op=%h dst=%0d mem=%h rd_en=%b, want iv=0 op=e dst=%0d mem=%h",
                 tag, issue_valid, opcode, dest_reg, storeDataAdr, imem_rd_en, ins[11:9], ins[3:0]);
      end
      @(negedge clk);
    end
    m_pc   = npc;
    m_last = ins;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_pc   = 8'h00;
    m_last = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_rd_en !== 1'b0 || opcode !== 4'h0 || issue_valid !== 1'b0 || halted !== 1'b0 ||
        pc !== 8'h00 || dest_reg !== 3'd0 || opAAdr !== 3'd0 || opBAder !== 3'd0 ||
        storeDataAdr !== 4'd0) begin
      errors++;
      $display("FAIL reset: rd_en=%b op=%h iv=%b hlt=%b pc=%h dst=%0d a=%0d b=%0d mem=%h, want all 0",
               imem_rd_en, opcode, issue_valid, halted, pc, dest_reg, opAAdr, opBAder, storeDataAdr);
    end
    release_reset();
  endtask

  task automatic test_program();
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0]  = 16'h1A08;
    mem[1]  = 16'hE403;
    mem[2]  = 16'hF04A;
    mem[3]  = 16'hC010;
    mem[4]  = 16'hD000;
    mem[16] = 16'hD000;
    for (int i = 0; i < 5; i++) run_instr("prog");
  endtask

  task automatic test_halt();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (halted !== 1'b1 || opcode !== 4'h0 || imem_rd_en !== 1'b0 ||
          issue_valid !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL halt cyc%0d: hlt=%b op=%h rd_en=%b iv=%b pc=%h, want 1/0/0/0 pc=%h",
                 i, halted, opcode, imem_rd_en, issue_valid, pc, m_pc);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || pc !== 8'h00 || imem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: hlt=%b pc=%h rd_en=%b, want 0/00/0", halted, pc, imem_rd_en);
    end
    release_reset();
    run_instr("resume");
  endtask

  task automatic test_reset_latch();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (imem_rd_en !== 1'b0 || opcode !== 4'h0 || issue_valid !== 1'b0 || pc !== 8'h00 ||
        dest_reg !== 3'd0 || opAAdr !== 3'd0 || opBAder !== 3'd0 || storeDataAdr !== 4'd0) begin
      errors++;
      $display("FAIL reset_latch: rd_en=%b op=%h iv=%b pc=%h dst=%0d a=%0d b=%0d mem=%h, want all 0",
               imem_rd_en, opcode, issue_valid, pc, dest_reg, opAAdr, opBAder, storeDataAdr);
    end
    release_reset();
    run_instr("after_latch_reset");
  endtask

  task automatic test_random();
    foreach (mem[i]) begin
      mem[i] = 16'($urandom);
      if (mem[i][15:12] == 4'hD) mem[i][15:12] = 4'($urandom_range(0, 11));
    end
    reset = 1'b1;
    release_reset();
    for (int i = 0; i < 150; i++) run_instr("random");
  endtask

  task automatic test_wrap();
    logic [3:0] ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                             4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
    foreach (mem[i]) mem[i] = {ops[$urandom_range(0, 13)], 12'($urandom)};
    reset = 1'b1;
    release_reset();
    for (int i = 0; i < 260; i++) run_instr("wrap");
    checks++;
    if (pc !== 8'd4) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h, want 04", pc);
    end
  endtask

  initial begin
    m_pc   = 8'h00;
    m_last = 16'h0000;
    test_reset();
    test_program();
    test_halt();
    test_reset_latch();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iu.md
Name: iu

Overview:
- Instruction unit: the issuing side of the execution-unit (eu) command interface.
- Fetches 16-bit instructions from instruction memory and decodes the fields.
- Drives eu inputs: opcode, opAAdr, opBAder, dest_reg, storeDataAdr.
- Sequences a multi-cycle fetch/issue loop; inserts the extra wait cycle eu needs for LOAD; supports HALT.

Parameters:
- PC_WIDTH, 8, instruction-memory address width; PC wraps modulo 2^PC_WIDTH.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  PC_WIDTH  instruction-memory read address.
- imem_rd_en  out  1  instruction-memory read strobe.
- imem_data  in  16  instruction word, valid the cycle after imem_rd_en.
- opcode  out  4  to eu.
- opAAdr  out  3  to eu, operand A register address.
- opBAder  out  3  to eu, operand B register address.
- dest_reg  out  3  to eu, destination register.
- storeDataAdr  out  4  to eu, data-memory address for LOAD/STORE.
- issue_valid  out  1  high for exactly the cycle an instruction is presented to eu.
- halted  out  1  high while in HALTED.
- pc  out  PC_WIDTH  current program counter (debug).

Behaviour:
- Instruction format: [15:12] opcode, [11:9] dest, [8:6] opA, [5:3] opB, [3:0] mem addr (LOAD/STORE only; overlaps opB low bit).
- Opcodes:
  - 0000 NOP.
  - 0001–1011 ALU ops, passed through to eu.
  - 1100 JMP, target in [7:0].
  - 1101 HALT.
  - 1110 LOAD: dest ← mem[addr].
  - 1111 STORE: mem[addr] ← reg[opA].
- States: FETCH, LATCH, ISSUE, LOAD_WAIT, HALTED.
- FETCH:
  - imem_rd_en=1, imem_addr=pc.
  - Next state LATCH.
- LATCH:
  - Capture imem_data into IR.
  - Next state ISSUE.
- ISSUE:
  - Drive decoded fields from IR; issue_valid=1.
  - pc ← pc+1, except for JMP and HALT.
  - Next state:
    - LOAD → LOAD_WAIT.
    - HALT → HALTED.
    - JMP → FETCH with pc ← IR[PC_WIDTH-1:0].
    - All others → FETCH.
- LOAD_WAIT:
  - Hold opcode=1110 and dest_reg/storeDataAdr stable so eu writes back; issue_valid=0.
  - Next state FETCH.
- HALTED:
  - Terminal until reset. opcode=0000, halted=1.
- Outside ISSUE/LOAD_WAIT: opcode=0000 (NOP) so eu never repeats a write. Address outputs keep their last values.
- Throughput: 3 cycles per instruction; 4 for LOAD.
- Reset values: state=FETCH, pc=RESET_PC, IR=0, opcode=0000, all address outputs 0, issue_valid=0, imem_rd_en=0 during reset, halted=0.
- Reset asserted mid-operation: immediate return to the reset values; any in-flight fetch is discarded.
- pc at all-ones followed by a non-jump instruction: wraps to 0.
- JMP to its own address: legal; loops forever.
- Fields not used by an opcode: still driven from IR bits, never X.

Optional Feature:
- Macro IU_JUMP_EN.
- Defined: opcode 1100 performs JMP as described.
- Undefined: opcode 1100 is issued to eu as NOP (opcode output 0000), pc ← pc+1; no jump logic is synthesized.

Decomposition:
- Package iu_pkg:
  - Opcode localparams OP_NOP, OP_JMP, OP_HALT, OP_LOAD, OP_STORE.
  - State enum iu_state_t.
  - Instruction field bit-position constants.
- One sub-module, iu_decode: purely combinational IR → field/class outputs (is_load, is_jmp, is_halt). The FSM and pc stay in iu.

Test Plan:
- Reset, imem[0]=16'h1A08 → FETCH at addr 0; on ISSUE (cycle 3), opcode=0001, dest_reg=5, opAAdr=0, opBAder=1, issue_valid=1; pc=1.
- imem[1]=16'hE403 (LOAD r2←mem[3]) → ISSUE opcode=1110, dest_reg=2, storeDataAdr=3; held through LOAD_WAIT; next FETCH at addr 2 after 4 cycles total.
- imem[2]=16'hF04A (STORE r1→mem[10]) → opcode=1111, opAAdr=1, storeDataAdr=4'hA, issue_valid=1 for one cycle.
- With IU_JUMP_EN, imem[3]=16'hC010 → next fetch imem_addr=8'h10. Without the macro → opcode stays 0000 and next fetch is addr 4.
- imem[4]=16'hD000 → halted=1, opcode=0000, imem_rd_en=0 indefinitely; reset pulse → pc=0, FETCH resumes.
- Reset asserted during LATCH → outputs at reset values in the same cycle; after release, first fetch is at RESET_PC.
